// File: rtl/input_debouncer_if.sv
// Raw board inputs and their debounced levels, edge pulses and sample strobe.
interface input_debouncer_if #(
  parameter int unsigned NB_BTN = 4,
  parameter int unsigned NB_SW  = 16
);
  logic [NB_BTN-1:0] btn_in;
  logic [NB_SW-1:0]  sw_in;
  logic [NB_BTN-1:0] btn_out;
  logic [NB_SW-1:0]  sw_out;
  logic [NB_BTN-1:0] btn_press;
  logic [NB_BTN-1:0] btn_release;
  logic              sw_changed;
  logic              tick;

  modport master (
    output btn_in, sw_in,
    input  btn_out, sw_out, btn_press, btn_release, sw_changed, tick
  );

  modport slave (
    input  btn_in, sw_in,
    output btn_out, sw_out, btn_press, btn_release, sw_changed, tick
  );
endinterface

// File: rtl/input_debouncer.sv
// Button/switch debouncer: 2-flop sync, tick prescaler, per-bit stability counters
// that accept a new level only after STABLE consecutive differing ticks.
module input_debouncer #(
  parameter int unsigned NB_BTN = 4,
  parameter int unsigned NB_SW  = 16,
  parameter int unsigned DIV    = 25000,
  parameter int unsigned STABLE = 8
) (
  input  logic              clk,
  input  logic              reset,
  input_debouncer_if.slave  bus
);

  localparam int unsigned NB = NB_BTN + NB_SW;
  localparam int unsigned PW = $clog2(DIV);
  localparam int unsigned CW = $clog2(STABLE + 1);

  logic [NB-1:0] meta_q;
  logic [NB-1:0] sync_q;
  logic [NB-1:0] out_q;
  logic [NB-1:0] out_nxt;
  logic [PW-1:0] pre_q;
  logic          tick_q;
  logic [CW-1:0] cnt_q   [NB];
  logic [CW-1:0] cnt_nxt [NB];
  logic [NB_BTN-1:0] press_q;
  logic [NB_BTN-1:0] release_q;
  logic              changed_q;

  // Switches occupy the upper bits, buttons the lower bits of every per-bit vector.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= {bus.sw_in, bus.btn_in};
      sync_q <= meta_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= (pre_q == PW'(DIV - 1));
      if (pre_q == PW'(DIV - 1)) pre_q <= '0;
      else                       pre_q <= pre_q + PW'(1);
    end
  end

  // Any tick that sees sync equal to the accepted level throws the count away.
  always_comb begin
    out_nxt = out_q;
    for (int i = 0; i < int'(NB); i++) cnt_nxt[i] = cnt_q[i];
    if (tick_q) begin
      for (int i = 0; i < int'(NB); i++) begin
        if (sync_q[i] == out_q[i]) begin
          cnt_nxt[i] = '0;
        end else if (cnt_q[i] == CW'(STABLE - 1)) begin
          out_nxt[i] = sync_q[i];
          cnt_nxt[i] = '0;
        end else begin
          cnt_nxt[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q     <= '0;
      press_q   <= '0;
      release_q <= '0;
      changed_q <= 1'b0;
      for (int i = 0; i < int'(NB); i++) cnt_q[i] <= '0;
    end else begin
      out_q     <= out_nxt;
      cnt_q     <= cnt_nxt;
      press_q   <= out_nxt[NB_BTN-1:0] & ~out_q[NB_BTN-1:0];
      release_q <= ~out_nxt[NB_BTN-1:0] & out_q[NB_BTN-1:0];
      changed_q <= |(out_nxt[NB-1:NB_BTN] ^ out_q[NB-1:NB_BTN]);
    end
  end

  assign bus.btn_out     = out_q[NB_BTN-1:0];
  assign bus.sw_out      = out_q[NB-1:NB_BTN];
  assign bus.btn_press   = press_q;
  assign bus.btn_release = release_q;
  assign bus.sw_changed  = changed_q;
  assign bus.tick        = tick_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with DIV=4, STABLE=3: edge-indexed vector table
// plus reset, bounce-rejection and mid-count-reset sequences.
module tb_input_debouncer;

  logic clk;
  logic reset;
  int   total;
  int   passed;

  input_debouncer_if #(.NB_BTN(4), .NB_SW(16)) bus ();

  input_debouncer #(
    .NB_BTN(4), .NB_SW(16), .DIV(4), .STABLE(3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  btn;
    logic [15:0] sw;
    int          adv;
    logic [3:0]  e_btn;
    logic [15:0] e_sw;
    logic [3:0]  e_press;
    logic [3:0]  e_rel;
    logic        e_chg;
    logic        e_tick;
  } vec_t;

  vec_t vecs [20];

  function automatic logic [31:0] outv();
    return {2'b00, bus.btn_out, bus.sw_out, bus.btn_press, bus.btn_release,
            bus.sw_changed, bus.tick};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  // Leaves the bench 1 ns after an edge with reset just released; the next edge is e1.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] b, input logic [15:0] s);
    reset = 1'b0;
    bus.btn_in = b;
    bus.sw_in  = s;
    step(3);
    chk("in_reset", outv(), 32'h0);
    reset = 1'b1;
  endtask

  initial begin
    int viol;
    logic [31:0] exp;
    total  = 0;
    passed = 0;
    reset  = 1'b0;
    bus.btn_in = '0;
    bus.sw_in  = '0;

    //             btn   sw        adv  e_btn e_sw      press rel  chg  tick   edge
    vecs[0]  = '{4'h1, 16'h0000,  4, 4'h0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b1}; // e4
    vecs[1]  = '{4'h1, 16'h0000,  1, 4'h0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0}; // e5
    vecs[2]  = '{4'h1, 16'h0000,  7, 4'h0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b1}; // e12
    vecs[3]  = '{4'h1, 16'h0000,  1, 4'h1, 16'h0000, 4'h1, 4'h0, 1'b0, 1'b0}; // e13
    vecs[4]  = '{4'h1, 16'h0000,  1, 4'h1, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0}; // e14
    vecs[5]  = '{4'h0, 16'h0000, 10, 4'h1, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b1}; // e24
    vecs[6]  = '{4'h0, 16'h0000,  1, 4'h0, 16'h0000, 4'h0, 4'h1, 1'b0, 1'b0}; // e25
    vecs[7]  = '{4'h0, 16'h0000,  1, 4'h0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0}; // e26
    vecs[8]  = '{4'h0, 16'hA5A5, 10, 4'h0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b1}; // e36
    vecs[9]  = '{4'h0, 16'hA5A5,  1, 4'h0, 16'hA5A5, 4'h0, 4'h0, 1'b1, 1'b0}; // e37
    vecs[10] = '{4'h0, 16'hA5A5,  1, 4'h0, 16'hA5A5, 4'h0, 4'h0, 1'b0, 1'b0}; // e38
    vecs[11] = '{4'hC, 16'hA5A5, 10, 4'h0, 16'hA5A5, 4'h0, 4'h0, 1'b0, 1'b1}; // e48
    vecs[12] = '{4'hC, 16'hA5A5,  1, 4'hC, 16'hA5A5, 4'hC, 4'h0, 1'b0, 1'b0}; // e49
    vecs[13] = '{4'hC, 16'hA5A5,  1, 4'hC, 16'hA5A5, 4'h0, 4'h0, 1'b0, 1'b0}; // e50
    vecs[14] = '{4'hC, 16'h0000,  3, 4'hC, 16'hA5A5, 4'h0, 4'h0, 1'b0, 1'b0}; // e53
    vecs[15] = '{4'hC, 16'hA5A5,  5, 4'hC, 16'hA5A5, 4'h0, 4'h0, 1'b0, 1'b0}; // e58
    vecs[16] = '{4'hC, 16'h0000,  7, 4'hC, 16'hA5A5, 4'h0, 4'h0, 1'b0, 1'b0}; // e65
    vecs[17] = '{4'hC, 16'h0000,  3, 4'hC, 16'hA5A5, 4'h0, 4'h0, 1'b0, 1'b1}; // e68
    vecs[18] = '{4'hC, 16'h0000,  1, 4'hC, 16'h0000, 4'h0, 4'h0, 1'b1, 1'b0}; // e69
    vecs[19] = '{4'hC, 16'h0000,  1, 4'hC, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0}; // e70

    // Main table: btn[0] held through reset release, then release, switch step, bounce.
    do_reset(4'h1, 16'h0000);
    for (int i = 0; i < 20; i++) begin
      bus.btn_in = vecs[i].btn;
      bus.sw_in  = vecs[i].sw;
      step(vecs[i].adv);
      exp = {2'b00, vecs[i].e_btn, vecs[i].e_sw, vecs[i].e_press, vecs[i].e_rel,
             vecs[i].e_chg, vecs[i].e_tick};
      chk($sformatf("vec%0d", i), outv(), exp);
    end

    // Reset clears outputs immediately, without waiting for a clock edge.
    #2 reset = 1'b0;
    #1 chk("async_clear", outv(), 32'h0);

    // All inputs high through reset; nothing may pulse on the release cycle.
    do_reset(4'hF, 16'hFFFF);
    step(1);
    chk("release_cycle", outv(), 32'h0);

    // btn[1] toggling every 5 clocks never survives 3 consecutive ticks.
    do_reset(4'h0, 16'h0000);
    viol = 0;
    for (int c = 0; c < 60; c++) begin
      if (c % 5 == 0) bus.btn_in[1] = ~bus.btn_in[1];
      step(1);
      if (bus.btn_out[1] || (bus.btn_press != 4'h0) || (bus.btn_release != 4'h0)) viol++;
    end
    chk("bounce_quiet", 32'(viol), 32'd0);
    chk("bounce_out", {28'h0, bus.btn_out}, 32'h0);

    // btn[2] held; reset after two ticks must discard the partial count.
    do_reset(4'h4, 16'h0000);
    step(9);
    chk("mid_pre", {28'h0, bus.btn_out}, 32'h0);
    #2 reset = 1'b0;
    step(2);
    chk("mid_reset", outv(), 32'h0);
    reset = 1'b1;
    step(12);
    chk("mid_e12", {24'h0, bus.btn_out, bus.btn_press}, 32'h00);
    step(1);
    chk("mid_e13", {24'h0, bus.btn_out, bus.btn_press}, 32'h44);
    step(1);
    chk("mid_e14", {24'h0, bus.btn_out, bus.btn_press}, 32'h40);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 SHALL have parameter NB_BTN, default 4, number of push-button inputs.
REQ-002 SHALL have parameter NB_SW, default 16, number of slide-switch inputs.
REQ-003 SHALL have parameter DIV, default 25000, clk cycles per sample tick (1 kHz at 25 MHz); legal range DIV >= 2.
REQ-004 SHALL have parameter STABLE, default 8, consecutive differing ticks required to accept a new level; legal range STABLE >= 1.
REQ-005 clk  input  1  single clock for all logic.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 btn_in  input  NB_BTN  raw, asynchronous board buttons.
REQ-008 sw_in  input  NB_SW  raw, asynchronous board switches.
REQ-009 btn_out  output  NB_BTN  debounced button levels (to PORTI).
REQ-010 sw_out  output  NB_SW  debounced switch levels (to PORTJ).
REQ-011 btn_press  output  NB_BTN  one-cycle pulse per bit on debounced 0->1.
REQ-012 btn_release  output  NB_BTN  one-cycle pulse per bit on debounced 1->0.
REQ-013 sw_changed  output  1  one-cycle pulse when any sw_out bit changes.
REQ-014 tick  output  1  one-cycle sample strobe.

Function
REQ-015 SHALL pass every btn_in/sw_in bit through a 2-flop synchronizer; the second-stage value is the "sync" bit.
REQ-016 SHALL implement a prescaler of $clog2(DIV) bits counting 0..DIV-1; it wraps to 0 after DIV-1; tick is registered and high for exactly the cycle after the prescaler equals DIV-1, i.e. one cycle in every DIV.
REQ-017 SHALL keep one stability counter per bit, width $clog2(STABLE+1), updated only on cycles where tick=1.
REQ-018 On tick, sync == out: counter cleared to 0 (a bounce discards all accumulated count).
REQ-019 On tick, sync != out, counter < STABLE-1: counter increments by 1.
REQ-020 On tick, sync != out, counter == STABLE-1: out bit loads sync, counter cleared to 0.
REQ-021 btn_press/btn_release/sw_changed SHALL be registered and asserted in the same cycle the corresponding out bit first shows its new value, and deasserted the next cycle.
REQ-022 Multiple bits changing on the same tick SHALL produce simultaneous pulses on each affected btn_press/btn_release bit and a single one-cycle sw_changed pulse.
REQ-023 Latency from a clean input step to out: 2 synchronizer cycles plus STABLE ticks; maximum 2 + STABLE*DIV + 1 clk cycles, minimum 2 + (STABLE-1)*DIV + 1.
REQ-024 No output SHALL change other than at a tick-qualified update, except by reset.
REQ-025 Logic SHALL be bit-parallel and independent per bit; no bit's counter affects another's.

Reset
REQ-026 reset low SHALL immediately and asynchronously clear synchronizers, prescaler, all stability counters, btn_out, sw_out, btn_press, btn_release, sw_changed and tick to 0.
REQ-027 Reset asserted mid-count SHALL discard partial counts; after release, a held input needs the full STABLE ticks again.
REQ-028 After reset release, the first tick SHALL occur DIV cycles after the first rising clk edge with reset high.

Verification (DIV=4, STABLE=3)
REQ-029 Reset with btn_in=4'hF, sw_in=16'hFFFF -> all outputs 0 while reset low; no pulse in the cycle reset is released.
REQ-030 Hold btn_in[0]=1 from reset release -> btn_out[0]=1 within 2+12+1 cycles, btn_press[0] high exactly 1 cycle, btn_release never.
REQ-031 Toggle btn_in[1] every 5 clks for 60 clks -> btn_out[1] stays 0, no pulses on btn_press/btn_release.
REQ-032 btn_in[0] 1->0 after debounced high -> btn_out[0]=0 after 3 ticks, btn_release[0] one pulse, no btn_press.
REQ-033 sw_in 16'h0000 -> 16'hA5A5 in one step -> sw_out=16'hA5A5 on a single update cycle, sw_changed exactly one pulse.
REQ-034 Hold btn_in[2]=1, assert reset after 2 ticks, release -> btn_out[2]=0 during reset, rises only after 3 further ticks.
